uart_rx_param: RTL and testbench

- Parametrised UART receiver. Successor to the fixed 8N1, 16-clocks-per-bit receiver.
- Adds configurable data width, oversample ratio, parity and stop-bit count, plus separate parity and framing error flags.
- Sits between the async serial pin and byte-level consumers. Output is a one-cycle `done` strobe with held parallel data.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync.sv | 38 +++
 rtl/uart_rx_param.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
//
// Contents:
//   rx_state_e            FSM state encoding for uart_rx_param
//   PARITY_NONE/EVEN/ODD  values accepted by the PARITY_MODE parameter
//   DEFAULT_CLKS_PER_BIT  default oversample ratio
//   maj3()                2-of-3 vote used when UART_RX_MAJORITY_EN is defined

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchroniser with falling-edge detect
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input (idle high)
//   q      out  synchronised level
//   fall   out  high for one cycle after q goes 1 -> 0

module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Flops reset to the idle-high level so leaving reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q    = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver (data width, oversample, parity, stop bits)
//
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 vote around mid-bit, +1 cycle latency)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   receiver enable; 0 forces idle and ignores the line
//   data_in     in   asynchronous serial line, idle high
//   busy        out  high from start-bit detect until return to idle
//   done        out  one-cycle strobe: frame complete
//   error       out  parity_err | frame_err, valid with done
//   parity_err  out  parity mismatch, valid with done
//   frame_err   out  a stop bit was sampled low, valid with done
//   data_out    out  received word (LSB first on the wire), held until next done

module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 data_in,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic [DATA_BITS-1:0] data_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after mid, so every decision moves one cycle later.
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
`else
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
`endif
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] N_STOP    = BW'(STOP_BITS);
    localparam logic          PAR_EXP   = (PARITY_MODE == PARITY_ODD);

    logic rx_s;
    logic rx_fall;
    logic sample_bit;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (data_in),
        .q     (rx_s),
        .fall  (rx_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] / hist_q[1] hold rx_s from one / two cycles back, giving
    // mid-1, mid and mid+1 when combined with the current rx_s.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample_bit = maj3(hist_q[1], hist_q[0], rx_s);
`else
    assign sample_bit = rx_s;
`endif

    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 perr_acc_q;
    logic                 ferr_acc_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic [DATA_BITS-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            data_q       <= '0;
        end else begin
            // Result flags are single-cycle pulses.
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (!en) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
                bit_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_fall) begin
                            state_q <= ST_START;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end

                    ST_START: begin
                        if (cnt_q == HALF_CNT) begin
                            cnt_q <= '0;
                            if (sample_bit) begin
                                // Line back high at mid start bit: glitch, not a frame.
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q    <= ST_DATA;
                                bit_q      <= '0;
                                par_q      <= 1'b0;
                                perr_acc_q <= 1'b0;
                                ferr_acc_q <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end

                    ST_DATA: begin
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            // LSB arrives first and ends up in bit 0 after the last shift.
                            shift_q <= {sample_bit, shift_q[DATA_BITS-1:1]};
                            par_q   <= par_q ^ sample_bit;
                            if (bit_q == LAST_DATA) begin
                                bit_q   <= '0;
                                state_q <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_q <= bit_q + BW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end

                    ST_PARITY: begin
                        if (cnt_q == LAST_CNT) begin
                            cnt_q      <= '0;
                            perr_acc_q <= (par_q ^ sample_bit) != PAR_EXP;
                            state_q    <= ST_STOP;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end

                    ST_STOP: begin
                        // bit_q counts stop samples taken; once all are in, the
                        // following cycle publishes the frame.
                        if (bit_q == N_STOP) begin
                            bit_q        <= '0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            data_q       <= shift_q;
                            parity_err_q <= perr_acc_q;
                            frame_err_q  <= ferr_acc_q;
                            error_q      <= perr_acc_q | ferr_acc_q;
                            // All-zero word with a low stop bit is a line break.
                            state_q      <= (ferr_acc_q && shift_q == '0) ? ST_BREAK : ST_IDLE;
                        end else if (cnt_q == LAST_CNT) begin
                            cnt_q <= '0;
                            bit_q <= bit_q + BW'(1);
                            if (!sample_bit) begin
                                ferr_acc_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end

                    ST_BREAK: begin
                        // Re-arm only once the line has returned high.
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign data_out   = data_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param (8N1/16x and 8E2/8x instances)

module tb_uart_rx_param;

    localparam int C0 = 16;
    localparam int C1 = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int L0 = 2 + C0/2 + C0*(8 + 0 + 1) + 1 + MAJ;
    localparam int L1 = 2 + C1/2 + C1*(8 + 1 + 2) + 1 + MAJ;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        longint     t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en   [2];
    logic       din  [2];
    logic       busy [2];
    logic       done [2];
    logic       error[2];
    logic       perr [2];
    logic       ferr [2];
    logic [7:0] dout [2];
    longint     cyc = 0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(
        .DATA_BITS(8), .CLKS_PER_BIT(C0), .PARITY_MODE(0), .STOP_BITS(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .data_in(din[0]),
        .busy(busy[0]), .done(done[0]), .error(error[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]), .data_out(dout[0])
    );

    uart_rx_param #(
        .DATA_BITS(8), .CLKS_PER_BIT(C1), .PARITY_MODE(1), .STOP_BITS(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .data_in(din[1]),
        .busy(busy[1]), .done(done[1]), .error(error[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]), .data_out(dout[1])
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the expected frame whenever a DUT strobes done.
    always @(posedge clk) begin
        exp_t e;
        #1;
        for (int ch = 0; ch < 2; ch++) begin
            if (done[ch]) begin
                if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
                    chk($sformatf("done_unexpected_ch%0d", ch), done[ch], 0);
                end else begin
                    if (ch == 0) e = q0.pop_front();
                    else         e = q1.pop_front();
                    chk($sformatf("data_ch%0d", ch), dout[ch], e.data);
                    chk($sformatf("parity_err_ch%0d", ch), perr[ch], e.perr);
                    chk($sformatf("frame_err_ch%0d", ch), ferr[ch], e.ferr);
                    chk($sformatf("error_ch%0d", ch), error[ch], e.perr | e.ferr);
                    chk($sformatf("done_cycle_ch%0d", ch), cyc, e.t);
                    chk($sformatf("busy_at_done_ch%0d", ch), busy[ch], 0);
                end
            end else begin
                chk($sformatf("flags_without_done_ch%0d", ch), {error[ch], perr[ch], ferr[ch]}, 0);
            end
        end
    end

    task automatic wait_cyc(input longint t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic idle(input int ch, input int n);
        repeat (n) begin
            @(negedge clk);
            din[ch] = 1'b1;
        end
    endtask

    // Drive one frame cycle by cycle. glitch_c flips the line for one cycle;
    // abort_c >= 0 aborts at that cycle (kind 1: reset, kind 2: en low).
    task automatic send(input int ch, input logic [7:0] data, input logic pbit,
                        input logic [1:0] stops, input int glitch_c,
                        input int abort_c, input int abort_kind, input int gap_bits);
        int         c_per;
        int         nb;
        logic [15:0] lv;
        longint     e0;
        exp_t       e;
        c_per = (ch == 0) ? C0 : C1;
        lv = '1;
        lv[0] = 1'b0;
        lv[8:1] = data;
        nb = 9;
        if (ch == 1) begin
            lv[9] = pbit;
            nb = 10;
        end
        lv[nb] = stops[0];
        nb++;
        if (ch == 1) begin
            lv[nb] = stops[1];
            nb++;
        end
        @(negedge clk);
        e0 = cyc + 1;
        if (abort_c < 0) begin
            e.data = data;
            if (ch == 0) begin
                e.perr = 1'b0;
                e.ferr = (stops[0] == 1'b0);
                e.t    = e0 + L0;
                q0.push_back(e);
            end else begin
                e.perr = (($countones(data) + int'(pbit)) % 2) != 0;
                e.ferr = (stops != 2'b11);
                e.t    = e0 + L1;
                q1.push_back(e);
            end
        end
        for (int c = 0; c < nb * c_per; c++) begin
            if (c > 0) @(negedge clk);
            if (c == abort_c) begin
                if (abort_kind == 1) begin
                    rst_n = 1'b0;
                    #1;
                    chk("reset_busy", busy[ch], 0);
                    chk("reset_done", done[ch], 0);
                    chk("reset_data_out", dout[ch], 0);
                    chk("reset_error", error[ch], 0);
                    din[ch] = 1'b1;
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    en[ch] = 1'b0;
                    @(posedge clk);
                    #1;
                    chk("en_abort_busy", busy[ch], 0);
                    chk("en_abort_done", done[ch], 0);
                    @(negedge clk);
                    en[ch] = 1'b1;
                    din[ch] = 1'b1;
                end
                idle(ch, gap_bits * c_per);
                return;
            end
            din[ch] = lv[c / c_per] ^ (c == glitch_c);
        end
        idle(ch, gap_bits * c_per);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       sb;
        logic [1:0] st;
        logic       pb;
        int         gap;
        longint     e0;

        en[0] = 1'b1; en[1] = 1'b1;
        din[0] = 1'b1; din[1] = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int ch = 0; ch < 2; ch++) begin
            chk("rst_busy", busy[ch], 0);
            chk("rst_done", done[ch], 0);
            chk("rst_data_out", dout[ch], 0);
            chk("rst_flags", {error[ch], perr[ch], ferr[ch]}, 0);
        end
        rst_n = 1'b1;
        idle(0, 4);

        // 8N1 basic frame, then random traffic including back-to-back.
        send(0, 8'hA5, 1'b0, 2'b11, -1, -1, 0, 2);
        for (int i = 0; i < 8; i++) begin
            d   = 8'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            gap = sb ? $urandom_range(0, 1) : 1 + $urandom_range(0, 1);
            send(0, d, 1'b0, {1'b1, sb}, -1, -1, 0, gap);
        end
        idle(0, 3 * C0);
        chk("pending_after_random_ch0", q0.size(), 0);

        // Reset during DATA, then a clean frame.
        send(0, 8'h33, 1'b0, 2'b11, -1, C0 * 3 + 5, 1, 2);
        send(0, 8'h5A, 1'b0, 2'b11, -1, -1, 0, 2);
        // en dropped mid-frame, then a clean frame.
        send(0, 8'hC3, 1'b0, 2'b11, -1, C0 * 5, 2, 2);
        chk("en_abort_data_held", dout[0], 8'h5A);
        send(0, 8'h5A, 1'b0, 2'b11, -1, -1, 0, 2);
        idle(0, 2 * C0);
        chk("pending_after_abort_ch0", q0.size(), 0);

        // 4-cycle low pulse: false start.
        @(negedge clk);
        e0 = cyc + 1;
        din[0] = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        din[0] = 1'b1;
        wait_cyc(e0 + 3);
        chk("false_start_busy_high", busy[0], 1);
        wait_cyc(e0 + 12);
        chk("false_start_busy_low", busy[0], 0);
        idle(0, 2 * C0);

        // Line held low 12 bit-times: one break frame, then silence.
        @(negedge clk);
        e0 = cyc + 1;
        begin
            exp_t e;
            e.data = 8'h00; e.perr = 1'b0; e.ferr = 1'b1; e.t = e0 + L0;
            q0.push_back(e);
        end
        din[0] = 1'b0;
        wait_cyc(e0 + L0 + 5);
        chk("break_busy_low", busy[0], 0);
        wait_cyc(e0 + 12 * C0);
        @(negedge clk);
        din[0] = 1'b1;
        idle(0, 3 * C0);
        chk("pending_after_break_ch0", q0.size(), 0);
        send(0, 8'h96, 1'b0, 2'b11, -1, -1, 0, 2);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle glitch at mid of data bit 3 must be voted out.
        send(0, 8'hA5, 1'b0, 2'b11, 4 * C0 + C0 / 2, -1, 0, 2);
`endif
        idle(0, C0);
        chk("pending_end_ch0", q0.size(), 0);

        // 8E2: wrong parity, bad second stop, then immediate clean 0xFF.
        send(1, 8'h3C, 1'b1, 2'b11, -1, -1, 0, 0);
        send(1, 8'h81, 1'b0, 2'b01, -1, -1, 0, 1);
        send(1, 8'hFF, 1'b0, 2'b11, -1, -1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            d  = 8'($urandom);
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            gap = (st != 2'b11) ? 1 : $urandom_range(0, 1);
            send(1, d, pb, st, -1, -1, 0, gap);
        end
        idle(1, 3 * C1);
        chk("pending_end_ch1", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
